// File: rtl/user_clock_lock_seq.sv
// User-clock lock sequencer.
//
// Holds the PLL in reset for a fixed number of cycles, then waits until the
// synchronised lock indication has been stable for a fixed number of
// consecutive cycles. After that it releases the per-channel user resets one
// at a time, a fixed stagger apart, and finally reports READY. Lock loss while
// releasing or running asserts all user resets at once, bumps a saturating
// lock-loss counter and re-runs the PLL reset. A restart request does the
// same without counting.
//
// Ports:
//   CLK          in   sole clock, rising edge
//   RST          in   synchronous active-high reset
//   LOCKED_IN    in   raw PLL lock, asynchronous to CLK
//   RESTART_IN   in   single-cycle request to re-run the PLL reset sequence
//   PLL_RST_OUT  out  active-high PLL reset
//   RST_N_OUT    out  per-channel active-low user resets [NUM_CHANNELS]
//   READY_OUT    out  all channels released and lock stable
//   RELOCK_COUNT out  saturating count of lock-loss events [8]
//
// Build option: define USER_CLOCK_LOCK_TIMEOUT_EN to retry the PLL reset when
// WAIT_LOCK has dwelt LOCK_TIMEOUT_CYCLES cycles without a stable lock.
// Without it WAIT_LOCK waits indefinitely and no timeout counter exists.

module user_clock_lock_seq #(
  parameter int NUM_CHANNELS        = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int STAGGER_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 4096
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LOCKED_IN,
  input  logic                    RESTART_IN,
  output logic                    PLL_RST_OUT,
  output logic [NUM_CHANNELS-1:0] RST_N_OUT,
  output logic                    READY_OUT,
  output logic [7:0]              RELOCK_COUNT
);

  // The cycle counter serves both the PLL reset hold and the release stagger.
  localparam int RelLastI = (NUM_CHANNELS - 1) * STAGGER_CYCLES;
  localparam int CntMax   = (PLL_RST_CYCLES > RelLastI) ? PLL_RST_CYCLES : RelLastI;
  localparam int CW       = $clog2(CntMax + 1);
  localparam int SW       = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [CW-1:0] PllLast    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] RelLast    = CW'(RelLastI);
  localparam logic [SW-1:0] StableLast = SW'(LOCK_STABLE_CYCLES - 1);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8 || PLL_RST_CYCLES < 1 ||
      LOCK_STABLE_CYCLES < 1 || STAGGER_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES <= LOCK_STABLE_CYCLES) begin : g_bad_cfg
    $error("user_clock_lock_seq: invalid parameter set");
  end

  typedef enum logic [1:0] {StPllReset, StWaitLock, StRelease, StRun} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [7:0]    relock_q, relock_d;
  logic          lock_meta_q, lock_s_q;

`ifdef USER_CLOCK_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] ToLast = TW'(LOCK_TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_q, to_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    relock_d = relock_q;
`ifdef USER_CLOCK_LOCK_TIMEOUT_EN
    to_d     = to_q;
`endif
    unique case (state_q)
      StPllReset: begin
        // RESTART_IN is deliberately ignored here.
        if (cnt_q == PllLast) begin
          state_d  = StWaitLock;
          cnt_d    = '0;
          stable_d = '0;
`ifdef USER_CLOCK_LOCK_TIMEOUT_EN
          to_d     = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (RESTART_IN) begin
          state_d = StPllReset;
          cnt_d   = '0;
        end else if (lock_s_q && stable_q == StableLast) begin
          state_d = StRelease;
          cnt_d   = '0;
`ifdef USER_CLOCK_LOCK_TIMEOUT_EN
        end else if (to_q == ToLast) begin
          state_d = StPllReset;
          cnt_d   = '0;
`endif
        end else begin
          stable_d = lock_s_q ? stable_q + 1'b1 : '0;
`ifdef USER_CLOCK_LOCK_TIMEOUT_EN
          to_d     = to_q + 1'b1;
`endif
        end
      end
      StRelease, StRun: begin
        // Lock loss wins over a coincident restart so it is counted.
        if (!lock_s_q) begin
          state_d = StPllReset;
          cnt_d   = '0;
          if (relock_q != 8'hFF) relock_d = relock_q + 1'b1;
        end else if (RESTART_IN) begin
          state_d = StPllReset;
          cnt_d   = '0;
        end else if (state_q == StRelease) begin
          if (cnt_q == RelLast) state_d = StRun;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StPllReset;
        cnt_d   = '0;
      end
    endcase
  end

  // Channel i releases once the stagger count reaches i*STAGGER_CYCLES; the
  // count only rises in StRelease, so a released channel stays released.
  always_comb begin
    RST_N_OUT = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (state_q == StRun) begin
        RST_N_OUT[i] = 1'b1;
      end else if (state_q == StRelease) begin
        RST_N_OUT[i] = (int'(cnt_q) >= i * STAGGER_CYCLES);
      end
    end
  end

  assign PLL_RST_OUT  = (state_q == StPllReset);
  assign READY_OUT    = (state_q == StRun);
  assign RELOCK_COUNT = relock_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StPllReset;
      cnt_q       <= '0;
      stable_q    <= '0;
      relock_q    <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
`ifdef USER_CLOCK_LOCK_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      relock_q    <= relock_d;
      lock_meta_q <= LOCKED_IN;
      lock_s_q    <= lock_meta_q;
`ifdef USER_CLOCK_LOCK_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_user_clock_lock_seq.sv
module tb_user_clock_lock_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOCKED_IN = 1'b0;
  logic       RESTART_IN = 1'b0;
  logic       PLL_RST_OUT;
  logic [1:0] RST_N_OUT;
  logic       READY_OUT;
  logic [7:0] RELOCK_COUNT;

  int chk_cnt  = 0;
  int pass_cnt = 0;

`ifdef USER_CLOCK_LOCK_TIMEOUT_EN
  localparam int ExpRepulse = 2;
`else
  localparam int ExpRepulse = 0;
`endif

  always #5 CLK = ~CLK;

  user_clock_lock_seq dut (
    .CLK          (CLK),
    .RST          (RST),
    .LOCKED_IN    (LOCKED_IN),
    .RESTART_IN   (RESTART_IN),
    .PLL_RST_OUT  (PLL_RST_OUT),
    .RST_N_OUT    (RST_N_OUT),
    .READY_OUT    (READY_OUT),
    .RELOCK_COUNT (RELOCK_COUNT)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Three reset edges; the next edge is cycle k=1 after release.
  task automatic do_reset();
    RST = 1'b1;
    RESTART_IN = 1'b0;
    tick(3);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    LOCKED_IN = 1'b1;
    RST = 1'b1;
    tick(3);
    chk_cnt++; if (PLL_RST_OUT !== 1'b1) $display("FAIL reset_pll got=%b exp=1", PLL_RST_OUT);
    else pass_cnt++;
    chk_cnt++; if (RST_N_OUT !== 2'b00) $display("FAIL reset_rstn got=%b exp=00", RST_N_OUT);
    else pass_cnt++;
    chk_cnt++; if (READY_OUT !== 1'b0) $display("FAIL reset_ready got=%b exp=0", READY_OUT);
    else pass_cnt++;
    chk_cnt++; if (RELOCK_COUNT !== 8'd0) $display("FAIL reset_count got=%0d exp=0", RELOCK_COUNT);
    else pass_cnt++;
    RST = 1'b0;
  endtask

  task automatic test_bringup();
    LOCKED_IN = 1'b1;
    do_reset();
    tick(15);  // k=15
    chk_cnt++; if (PLL_RST_OUT !== 1'b1) $display("FAIL bring_pll_k15 got=%b exp=1", PLL_RST_OUT);
    else pass_cnt++;
    tick(1);   // k=16
    chk_cnt++; if (PLL_RST_OUT !== 1'b0) $display("FAIL bring_pll_k16 got=%b exp=0", PLL_RST_OUT);
    else pass_cnt++;
    tick(63);  // k=79
    chk_cnt++; if (RST_N_OUT !== 2'b00) $display("FAIL bring_rstn_k79 got=%b exp=00", RST_N_OUT);
    else pass_cnt++;
    tick(1);   // k=80
    chk_cnt++; if (RST_N_OUT !== 2'b01) $display("FAIL bring_rstn_k80 got=%b exp=01", RST_N_OUT);
    else pass_cnt++;
    tick(7);   // k=87
    chk_cnt++; if (RST_N_OUT !== 2'b01) $display("FAIL bring_rstn_k87 got=%b exp=01", RST_N_OUT);
    else pass_cnt++;
    tick(1);   // k=88
    chk_cnt++; if (RST_N_OUT !== 2'b11) $display("FAIL bring_rstn_k88 got=%b exp=11", RST_N_OUT);
    else pass_cnt++;
    chk_cnt++; if (READY_OUT !== 1'b0) $display("FAIL bring_ready_k88 got=%b exp=0", READY_OUT);
    else pass_cnt++;
    tick(1);   // k=89
    chk_cnt++; if (READY_OUT !== 1'b1) $display("FAIL bring_ready_k89 got=%b exp=1", READY_OUT);
    else pass_cnt++;
  endtask

  // Continues from RUN left by test_bringup.
  task automatic test_lock_loss();
    tick(5);
    LOCKED_IN = 1'b0;
    tick(2);
    chk_cnt++; if (READY_OUT !== 1'b1) $display("FAIL loss_ready_sync got=%b exp=1", READY_OUT);
    else pass_cnt++;
    tick(1);
    chk_cnt++; if (RST_N_OUT !== 2'b00) $display("FAIL loss_rstn got=%b exp=00", RST_N_OUT);
    else pass_cnt++;
    chk_cnt++; if (READY_OUT !== 1'b0) $display("FAIL loss_ready got=%b exp=0", READY_OUT);
    else pass_cnt++;
    chk_cnt++; if (RELOCK_COUNT !== 8'd1) $display("FAIL loss_count got=%0d exp=1", RELOCK_COUNT);
    else pass_cnt++;
    tick(15);
    chk_cnt++; if (PLL_RST_OUT !== 1'b1) $display("FAIL loss_pll_15 got=%b exp=1", PLL_RST_OUT);
    else pass_cnt++;
    tick(1);
    chk_cnt++; if (PLL_RST_OUT !== 1'b0) $display("FAIL loss_pll_16 got=%b exp=0", PLL_RST_OUT);
    else pass_cnt++;
    LOCKED_IN = 1'b1;
  endtask

  task automatic test_glitch();
    LOCKED_IN = 1'b1;
    do_reset();
    tick(56);  // stable count reaches 40
    LOCKED_IN = 1'b0;
    tick(1);
    LOCKED_IN = 1'b1;
    tick(23);  // k=80, undisturbed release point
    chk_cnt++; if (RST_N_OUT !== 2'b00) $display("FAIL glitch_rstn_k80 got=%b exp=00", RST_N_OUT);
    else pass_cnt++;
    tick(42);  // k=122
    chk_cnt++; if (RST_N_OUT !== 2'b00) $display("FAIL glitch_rstn_k122 got=%b exp=00", RST_N_OUT);
    else pass_cnt++;
    tick(1);   // k=123
    chk_cnt++; if (RST_N_OUT !== 2'b01) $display("FAIL glitch_rstn_k123 got=%b exp=01", RST_N_OUT);
    else pass_cnt++;
    tick(9);   // k=132
    chk_cnt++; if (READY_OUT !== 1'b1) $display("FAIL glitch_ready_k132 got=%b exp=1", READY_OUT);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    LOCKED_IN = 1'b1;
    do_reset();
    tick(89);
    RESTART_IN = 1'b1;
    tick(1);   // j=0: PLL_RESET entered
    RESTART_IN = 1'b0;
    chk_cnt++; if (PLL_RST_OUT !== 1'b1) $display("FAIL restart_pll got=%b exp=1", PLL_RST_OUT);
    else pass_cnt++;
    chk_cnt++; if (RST_N_OUT !== 2'b00) $display("FAIL restart_rstn got=%b exp=00", RST_N_OUT);
    else pass_cnt++;
    chk_cnt++; if (RELOCK_COUNT !== 8'd0) $display("FAIL restart_count got=%0d exp=0", RELOCK_COUNT);
    else pass_cnt++;
    tick(5);
    RESTART_IN = 1'b1;  // ignored in PLL_RESET
    tick(1);   // j=6
    RESTART_IN = 1'b0;
    tick(9);   // j=15
    chk_cnt++; if (PLL_RST_OUT !== 1'b1) $display("FAIL restart_pll_j15 got=%b exp=1", PLL_RST_OUT);
    else pass_cnt++;
    tick(1);   // j=16
    chk_cnt++; if (PLL_RST_OUT !== 1'b0) $display("FAIL restart_ign got=%b exp=0", PLL_RST_OUT);
    else pass_cnt++;
    tick(10);
    RESTART_IN = 1'b1;  // in WAIT_LOCK
    tick(1);   // j=27
    RESTART_IN = 1'b0;
    chk_cnt++; if (PLL_RST_OUT !== 1'b1) $display("FAIL restart_wait got=%b exp=1", PLL_RST_OUT);
    else pass_cnt++;
    tick(89);  // j=116
    chk_cnt++; if (READY_OUT !== 1'b1) $display("FAIL restart_relock got=%b exp=1", READY_OUT);
    else pass_cnt++;
  endtask

  // Continues from RUN left by test_restart (count 0).
  task automatic test_back_to_back();
    LOCKED_IN = 1'b0;
    tick(2);
    RESTART_IN = 1'b1;  // sampled on the same edge lock loss acts
    tick(1);
    RESTART_IN = 1'b0;
    chk_cnt++; if (RELOCK_COUNT !== 8'd1) $display("FAIL both_count got=%0d exp=1", RELOCK_COUNT);
    else pass_cnt++;
    chk_cnt++; if (PLL_RST_OUT !== 1'b1) $display("FAIL both_pll got=%b exp=1", PLL_RST_OUT);
    else pass_cnt++;
    tick(16);
    chk_cnt++; if (PLL_RST_OUT !== 1'b0) $display("FAIL both_pll_16 got=%b exp=0", PLL_RST_OUT);
    else pass_cnt++;
    tick(20);
    chk_cnt++; if (RELOCK_COUNT !== 8'd1) $display("FAIL both_count_hold got=%0d exp=1", RELOCK_COUNT);
    else pass_cnt++;
    LOCKED_IN = 1'b1;
  endtask

  task automatic test_mid_reset();
    LOCKED_IN = 1'b1;
    do_reset();
    tick(89);
    LOCKED_IN = 1'b0;
    tick(2);
    RST = 1'b1;  // coincides with the lock-loss edge
    tick(1);
    RST = 1'b0;
    LOCKED_IN = 1'b1;
    chk_cnt++; if (RELOCK_COUNT !== 8'd0) $display("FAIL midrst_count got=%0d exp=0", RELOCK_COUNT);
    else pass_cnt++;
    chk_cnt++; if (PLL_RST_OUT !== 1'b1) $display("FAIL midrst_pll got=%b exp=1", PLL_RST_OUT);
    else pass_cnt++;
    tick(15);
    chk_cnt++; if (PLL_RST_OUT !== 1'b1) $display("FAIL midrst_pll_15 got=%b exp=1", PLL_RST_OUT);
    else pass_cnt++;
    tick(1);
    chk_cnt++; if (PLL_RST_OUT !== 1'b0) $display("FAIL midrst_pll_16 got=%b exp=0", PLL_RST_OUT);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    int n;
    LOCKED_IN = 1'b1;
    do_reset();
    for (int e = 0; e < 300; e++) begin
      n = 0;
      while (RST_N_OUT[0] !== 1'b1 && n < 300) begin tick(1); n++; end
      if (n >= 300) begin
        chk_cnt++;
        $display("FAIL sat_wait_release event=%0d rstn=%b exp=release", e, RST_N_OUT);
        break;
      end
      LOCKED_IN = 1'b0;
      n = 0;
      while (PLL_RST_OUT !== 1'b1 && n < 10) begin tick(1); n++; end
      if (n >= 10) begin
        chk_cnt++;
        $display("FAIL sat_wait_pll event=%0d pll=%b exp=1", e, PLL_RST_OUT);
        break;
      end
      LOCKED_IN = 1'b1;
      if (e == 0) begin
        chk_cnt++; if (RELOCK_COUNT !== 8'd1) $display("FAIL sat_count_1 got=%0d exp=1", RELOCK_COUNT);
        else pass_cnt++;
      end
      if (e == 99) begin
        chk_cnt++;
        if (RELOCK_COUNT !== 8'd100) $display("FAIL sat_count_100 got=%0d exp=100", RELOCK_COUNT);
        else pass_cnt++;
      end
      if (e == 254 || e == 299) begin
        chk_cnt++;
        if (RELOCK_COUNT !== 8'd255) $display("FAIL sat_count_%0d got=%0d exp=255", e + 1, RELOCK_COUNT);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_timeout();
    int rises;
    logic prev;
    LOCKED_IN = 1'b0;
    do_reset();
    rises = 0;
    prev = 1'b1;
    for (int k = 1; k <= 8300; k++) begin
      tick(1);
      if (PLL_RST_OUT === 1'b1 && prev === 1'b0) rises++;
      prev = PLL_RST_OUT;
      if (k == 4112) begin
        chk_cnt++;
        if (PLL_RST_OUT !== (ExpRepulse != 0))
          $display("FAIL timeout_pll_k4112 got=%b exp=%0d", PLL_RST_OUT, ExpRepulse != 0);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (rises !== ExpRepulse) $display("FAIL timeout_repulses got=%0d exp=%0d", rises, ExpRepulse);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_glitch();
    test_restart();
    test_back_to_back();
    test_mid_reset();
    test_saturate();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/user_clock_lock_seq.md
USER_CLOCK_LOCK_SEQ -- requirements
Module: user_clock_lock_seq

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2, number of gated user-clock reset channels (1..8).
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 16, cycles PLL_RST_OUT is held per reset attempt (>=1).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 64, consecutive synchronised-lock cycles required before release (>=1).
REQ-004 SHALL have parameter STAGGER_CYCLES, default 8, cycles between successive channel reset releases (>=1).
REQ-005 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 4096, maximum WAIT_LOCK dwell (>LOCK_STABLE_CYCLES).
REQ-006 Ports: CLK  in  1  sole clock; all logic on rising edge.
REQ-007 Ports: RST  in  1  reset; synchronous, active-high.
REQ-008 Ports: LOCKED_IN  in  1  raw PLL lock, asynchronous to CLK.
REQ-009 Ports: RESTART_IN  in  1  single-cycle request to re-run the full PLL reset sequence.
REQ-010 Ports: PLL_RST_OUT  out  1  active-high reset to the PLL primitive.
REQ-011 Ports: RST_N_OUT  out  NUM_CHANNELS  per-channel active-low user resets.
REQ-012 Ports: READY_OUT  out  1  high only when all channels released and lock stable.
REQ-013 Ports: RELOCK_COUNT  out  8  saturating count of lock-loss events.

Function
REQ-014 LOCKED_IN SHALL pass a 2-flop synchroniser; all decisions use the synchronised value (lock_s).
REQ-015 FSM states SHALL be PLL_RESET, WAIT_LOCK, RELEASE, RUN.
REQ-016 PLL_RESET: PLL_RST_OUT=1, all RST_N_OUT=0; after exactly PLL_RST_CYCLES cycles go to WAIT_LOCK.
REQ-017 WAIT_LOCK: PLL_RST_OUT=0; stable counter increments while lock_s=1, clears on lock_s=0; on reaching LOCK_STABLE_CYCLES go to RELEASE.
REQ-018 RELEASE: channel i SHALL deassert RST_N_OUT[i] (go 1) i*STAGGER_CYCLES cycles after entry, channel 0 on the first RELEASE cycle; after channel NUM_CHANNELS-1 released, go to RUN next cycle.
REQ-019 RUN: READY_OUT=1, all RST_N_OUT=1; READY_OUT SHALL be 0 in every other state.
REQ-020 Lock loss (lock_s=0) in RELEASE or RUN SHALL, on the same edge, drive all RST_N_OUT=0, READY_OUT=0, increment RELOCK_COUNT (saturate at 255), enter PLL_RESET.
REQ-021 RESTART_IN=1 in any state except PLL_RESET SHALL enter PLL_RESET next cycle with all RST_N_OUT=0; RELOCK_COUNT unchanged; ignored in PLL_RESET.
REQ-022 Lock loss and RESTART_IN in the same cycle: lock loss takes precedence (count increments once).
REQ-023 Released channels SHALL never re-assert individually; resets assert only all-together per REQ-020/021.
REQ-024 Counters SHALL be sized $clog2 of their limit+1; no wrap-around permitted.

Reset
REQ-025 RST=1 SHALL force state PLL_RESET with cycle counter cleared, PLL_RST_OUT=1, RST_N_OUT all 0, READY_OUT=0, RELOCK_COUNT=0, synchroniser flops 0.
REQ-026 RST asserted mid-sequence SHALL take precedence over all other inputs on that edge.

Configuration
REQ-027 Macro USER_CLOCK_LOCK_TIMEOUT_EN defined: WAIT_LOCK dwell of LOCK_TIMEOUT_CYCLES without success SHALL return to PLL_RESET (retry, RELOCK_COUNT unchanged).
REQ-028 Macro undefined: WAIT_LOCK waits indefinitely; timeout counter not instantiated.

Verification
REQ-029 Defaults, RST 3 cycles then LOCKED_IN=1 constant -> PLL_RST_OUT high 16 cycles, RST_N_OUT[0] rises after 64+2 sync cycles, RST_N_OUT[1] 8 cycles later, READY_OUT next cycle.
REQ-030 LOCKED_IN glitches low for 1 cycle at stable count 40 -> counter restarts; release delayed by 64 cycles from glitch recovery.
REQ-031 In RUN, drop LOCKED_IN -> 2 sync cycles later RST_N_OUT=00, READY_OUT=0, RELOCK_COUNT 0->1, PLL_RST_OUT high 16 cycles.
REQ-032 300 lock-loss events -> RELOCK_COUNT holds 255.
REQ-033 With USER_CLOCK_LOCK_TIMEOUT_EN, LOCKED_IN=0 forever -> PLL_RST_OUT re-pulses every 16+4096 cycles; without macro, single pulse only.
REQ-034 RESTART_IN and lock loss same cycle in RUN -> one PLL_RESET entry, RELOCK_COUNT +1.
